// File: rtl/resistive_n_way_mixer.sv
// N-input passive resistor mixer: out = sum(Vi/Ri) / sum(1/Ri), one weighted MAC per clk.
// Optional build macro RESISTIVE_MIXER_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module resistive_n_way_mixer #(
    parameter int           N      = 4,
    parameter int           WIDTH  = 16,
    parameter logic [255:0] R_LIST = {8{32'd10000}}
) (
    input  logic             clk,
    input  logic             I_RSTn,
    input  logic             audio_clk_en,
    input  logic [WIDTH-1:0] inputs [N-1:0],
    input  logic [N-1:0]     mute,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
    output logic [7:0]       overrun_cnt,
`endif
    output logic             busy
);

    localparam int ACC_W = WIDTH + 17;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Conductance in 2^-32 siemens units; a zero resistor is flagged below and treated as open here.
    function automatic logic [63:0] cond_of(input int i);
        logic [63:0] r;
        r = 64'(R_LIST[32*i +: 32]);
        return (r == 64'd0) ? 64'd0 : (64'd1 << 32) / r;
    endfunction

    function automatic logic [16:0] weight_of(input int i);
        logic [63:0] g_sum;
        g_sum = 64'd0;
        for (int j = 0; j < N; j++) g_sum = g_sum + cond_of(j);
        return (g_sum == 64'd0) ? 17'd0 : 17'((cond_of(i) << 16) / g_sum);
    endfunction

    if (N < 2 || N > 8) begin : g_bad_n
        $error("resistive_n_way_mixer: N=%0d outside legal range 2..8", N);
    end

    logic [16:0] w_tab [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_weight
        localparam logic [16:0] W_I = weight_of(gi);
        if (R_LIST[32*gi +: 32] == 32'd0) begin : g_bad_r
            $error("resistive_n_way_mixer: R_LIST entry %0d is zero", gi);
        end
        assign w_tab[gi] = W_I;
    end

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] snap [N];
    logic [WIDTH:0]   acc_top;

    assign acc_top = acc[ACC_W-1:16];

    // Strobes that arrive outside IDLE fall through the case untouched, so a running mix is never disturbed.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N; i++) snap[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (audio_clk_en) begin
                        for (int i = 0; i < N; i++) snap[i] <= mute[i] ? '0 : inputs[i];
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(w_tab[idx]) * ACC_W'(snap[idx]);
                    if (idx == IDX_W'(N - 1)) begin
                        state <= OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    out       <= acc_top[WIDTH] ? '1 : acc_top[WIDTH-1:0];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            overrun_cnt <= '0;
        end else if (audio_clk_en && state != IDLE && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_resistive_n_way_mixer.sv
// Randomized self-checking bench for resistive_n_way_mixer against a plain-arithmetic mixing model.
// Two instances: four equal 10k resistors, and a 10k/30k pair with unequal weights.
module tb_resistive_n_way_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        I_RSTn;
    logic        en_a, en_b;
    logic [15:0] in_a [3:0];
    logic [15:0] in_b [1:0];
    logic [3:0]  mute_a;
    logic [1:0]  mute_b;
    logic [15:0] out_a, out_b;
    logic        valid_a, valid_b, busy_a, busy_b;
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
    logic [7:0]  ovr_a, ovr_b;
`endif

    int checks = 0;
    int passed = 0;
    int ovr_exp_a = 0;
    int ovr_exp_b = 0;
    longint unsigned ra [8];
    longint unsigned rb [8];

    resistive_n_way_mixer #(.N(4), .WIDTH(16), .R_LIST({8{32'd10000}})) dut_a (
        .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(en_a), .inputs(in_a), .mute(mute_a),
        .out(out_a), .out_valid(valid_a),
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
        .overrun_cnt(ovr_a),
`endif
        .busy(busy_a)
    );

    resistive_n_way_mixer #(.N(2), .WIDTH(16), .R_LIST({192'd0, 32'd30000, 32'd10000})) dut_b (
        .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(en_b), .inputs(in_b), .mute(mute_b),
        .out(out_b), .out_valid(valid_b),
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
        .overrun_cnt(ovr_b),
`endif
        .busy(busy_b)
    );

    task automatic checkOutput(input string tag, input longint got, input longint expv);
        checks++;
        if (got == expv) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    endtask

    // Node voltage of N sources through resistors, in the fixed-point form the block promises.
    function automatic longint unsigned mixModel(input int n, input longint unsigned r [8],
                                                 input longint unsigned v [8], input logic [7:0] m);
        longint unsigned g [8];
        longint unsigned gsum, w, total;
        gsum  = 0;
        total = 0;
        for (int i = 0; i < n; i++) begin
            g[i] = (64'd1 << 32) / r[i];
            gsum += g[i];
        end
        for (int i = 0; i < n; i++) begin
            w = (g[i] << 16) / gsum;
            if (!m[i]) total += w * v[i];
        end
        total = total >> 16;
        return (total > 65535) ? 65535 : total;
    endfunction

    task automatic setEn(input int which, input logic e);
        if (which == 0) en_a = e;
        else en_b = e;
    endtask

    function automatic logic validOf(input int which);
        return (which == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic busyOf(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [15:0] outOf(input int which);
        return (which == 0) ? out_a : out_b;
    endfunction

    // One mix: strobe, scramble inputs right after the snapshot, optionally re-strobe while busy.
    task automatic applyStimulus(input int which, input logic [7:0] m, input string tag,
                                 input int ovr_first, input int ovr_count);
        longint unsigned v [8];
        longint          exp_out;
        int              n, cyc, extra;
        for (int i = 0; i < 8; i++) v[i] = 0;
        if (which == 0) begin
            n = 4;
            for (int i = 0; i < 4; i++) v[i] = in_a[i];
            exp_out = longint'(mixModel(n, ra, v, m));
        end else begin
            n = 2;
            for (int i = 0; i < 2; i++) v[i] = in_b[i];
            exp_out = longint'(mixModel(n, rb, v, m));
        end
        @(posedge clk); #1;
        mute_a = m[3:0];
        mute_b = m[1:0];
        setEn(which, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) in_a[i] = 16'($urandom);
        for (int i = 0; i < 2; i++) in_b[i] = 16'($urandom);
        mute_a = 4'($urandom);
        mute_b = 2'($urandom);
        checkOutput({tag, " busy"}, longint'(busyOf(which)), 1);
        cyc = 0;
        setEn(which, cyc >= ovr_first && cyc < ovr_first + ovr_count);
        while (!validOf(which) && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            setEn(which, cyc >= ovr_first && cyc < ovr_first + ovr_count);
        end
        setEn(which, 1'b0);
        if (which == 0) ovr_exp_a = (ovr_exp_a + ovr_count > 255) ? 255 : ovr_exp_a + ovr_count;
        else ovr_exp_b = (ovr_exp_b + ovr_count > 255) ? 255 : ovr_exp_b + ovr_count;
        checkOutput({tag, " latency"}, cyc, n + 1);
        checkOutput({tag, " out"}, longint'(outOf(which)), exp_out);
        @(posedge clk); #1;
        checkOutput({tag, " valid drop"}, longint'(validOf(which)), 0);
        checkOutput({tag, " busy drop"}, longint'(busyOf(which)), 0);
        checkOutput({tag, " out hold"}, longint'(outOf(which)), exp_out);
        extra = 0;
        for (int k = 0; k < n + 3; k++) begin
            @(posedge clk); #1;
            if (validOf(which)) extra++;
        end
        checkOutput({tag, " extra valid"}, extra, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ra[i] = 10000;
            rb[i] = 10000;
        end
        rb[1] = 30000;
        I_RSTn = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        mute_a = '0;
        mute_b = '0;
        for (int i = 0; i < 4; i++) in_a[i] = 16'h0;
        for (int i = 0; i < 2; i++) in_b[i] = 16'h0;
        #2 I_RSTn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_a", longint'(out_a), 0);
        checkOutput("reset valid_a", longint'(valid_a), 0);
        checkOutput("reset busy_a", longint'(busy_a), 0);
        checkOutput("reset out_b", longint'(out_b), 0);
        #3 I_RSTn = 1'b1;

        for (int i = 0; i < 4; i++) in_a[i] = 16'hFFFF;
        applyStimulus(0, 8'h00, "full scale", 0, 0);
        checkOutput("full scale const", longint'(out_a), 16'hFFFF);
        for (int i = 0; i < 4; i++) in_a[i] = 16'hFFFF;
        applyStimulus(0, 8'h05, "mute 0101", 0, 0);
        checkOutput("mute 0101 const", longint'(out_a), 16'h7FFF);

        in_b[0] = 16'h0000;
        in_b[1] = 16'hFFFF;
        applyStimulus(1, 8'h00, "10k/30k", 0, 0);
        checkOutput("10k/30k const", longint'(out_b), 16'h3FFE);

        for (int i = 0; i < 4; i++) in_a[i] = 16'h1234 * 16'(i + 1);
        applyStimulus(0, 8'h00, "overrun one", 1, 1);
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
        checkOutput("overrun cnt one", longint'(ovr_a), 1);
`endif
        for (int k = 0; k < 75; k++) begin
            for (int i = 0; i < 4; i++) in_a[i] = 16'($urandom);
            applyStimulus(0, 8'($urandom_range(0, 15)), "overrun stress", 0, 4);
        end
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
        checkOutput("overrun cnt sat", longint'(ovr_a), 255);
        checkOutput("overrun cnt b", longint'(ovr_b), ovr_exp_b);
`endif

        // Abort a mix mid-accumulation; outputs must clear without waiting for a clock.
        for (int i = 0; i < 4; i++) in_a[i] = 16'hFFFF;
        @(posedge clk); #1;
        mute_a = 4'h0;
        en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        @(posedge clk); #1;
        I_RSTn = 1'b0;
        #1;
        checkOutput("abort out_a", longint'(out_a), 0);
        checkOutput("abort busy_a", longint'(busy_a), 0);
        checkOutput("abort valid_a", longint'(valid_a), 0);
        checkOutput("abort out_b", longint'(out_b), 0);
        #3 I_RSTn = 1'b1;
        ovr_exp_a = 0;
        ovr_exp_b = 0;
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
        checkOutput("abort ovr cnt", longint'(ovr_a), 0);
`endif
        for (int i = 0; i < 4; i++) in_a[i] = 16'h4000 + 16'(i);
        applyStimulus(0, 8'h00, "after abort", 0, 0);

        for (int k = 0; k < 24; k++) begin
            int which;
            int ovr;
            which = k % 2;
            ovr = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int i = 0; i < 4; i++) in_a[i] = 16'($urandom);
            for (int i = 0; i < 2; i++) in_b[i] = 16'($urandom);
            applyStimulus(which, 8'($urandom), "random", 1, ovr);
        end
`ifdef RESISTIVE_MIXER_OVERRUN_CNT_EN
        checkOutput("final ovr a", longint'(ovr_a), ovr_exp_a);
        checkOutput("final ovr b", longint'(ovr_b), ovr_exp_b);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
